// File: rtl/acc_drain.sv
// Output stage for one systolic column: ping-pong capture of R accumulators,
// requantise (round, shift, saturate) and drain one word per beat onto AXI-Stream.
module acc_drain #(
    parameter int R     = 4,
    parameter int WY    = 32,
    parameter int WO    = 8,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [R*WY-1:0] s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [WO-1:0]   m_data,
    output logic            m_last
);

    localparam int            IW   = (R > 1) ? $clog2(R) : 1;
    localparam logic [IW-1:0] LAST = IW'(R - 1);

    // Requantisation constants, all in WY+1 bits so the rounding add cannot wrap.
    localparam logic signed [WY:0] RND  = ({{WY{1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [WY:0] QMAX = {{(WY-WO+2){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [WY:0] QMIN = {{(WY-WO+2){1'b1}}, {(WO-1){1'b0}}};

    logic [WY-1:0] bank [2][R];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    cnt;
    logic [IW-1:0] idx;
    logic          cap, beat, fin;

    assign s_ready = (cnt != 2'd2);
    assign m_valid = (cnt != 2'd0);
    assign m_last  = m_valid && (idx == LAST);
    assign cap     = s_valid && s_ready;
    assign beat    = m_valid && m_ready;
    assign fin     = beat && (idx == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < R; r++)
                    bank[b][r] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            idx    <= '0;
        end else begin
            if (cap) begin
                for (int r = 0; r < R; r++)
                    bank[wr_ptr][r] <= s_data[r*WY +: WY];
                wr_ptr <= ~wr_ptr;
            end
            if (beat) begin
                if (fin) begin
                    idx    <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
            // Capture and packet completion in the same cycle cancel out.
            case ({cap, fin})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    logic signed [WY:0] xe, t;

    always_comb begin
        xe = {bank[rd_ptr][idx][WY-1], bank[rd_ptr][idx]};
        t  = (xe + RND) >>> SHIFT;
        if (t > QMAX)
            m_data = QMAX[WO-1:0];
        else if (t < QMIN)
            m_data = QMIN[WO-1:0];
        else
            m_data = t[WO-1:0];
    end

endmodule
